i2c_raw_tx: RTL
===============

Name: i2c_raw_tx

Overview:
- Clocked I2C master write transmitter: the generating end of the bus that the i2c_raw sniffer decodes.
- On a start request it emits START, a 7-bit address with W=0, one or more data bytes fed through a valid/ready handshake, and STOP.
- Samples ACK from the target after every byte.
- Drives SCL push-pull and SDA as open-drain (value plus enable); a pad or tri-state wrapper sits outside this block.

Parameters:
QDIV, 4, clocks per SCL quarter-period (must be >=1); one SCL bit period = 4*QDIV clocks.

Ports:
clk  input  1  system clock, all state changes on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  request transaction; accepted only in IDLE
addr  input  7  target address, captured when start is accepted
data_in  input  8  byte to send, captured on handshake
data_last  input  1  byte being handed over is the final one, captured with data_in
data_valid  input  1  data_in/data_last valid
data_ready  output  1  high while block waits for the next byte (LOAD state)
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when STOP completes
nack  output  1  sticky: last transaction ended on NACK; cleared when the next start is accepted
scl  output  1  SCL line
sda_o  output  1  SDA drive value (0 when driving)
sda_oe  output  1  1 = drive SDA low, 0 = release SDA (pulled high externally)
sda_i  input  1  sampled SDA line, used for ACK

Behaviour:
- Reset (async, immediate): state IDLE, scl=1, sda_oe=0, sda_o=0, data_ready=0, busy=0, done=0, nack=0, counters cleared. Reset mid-transaction aborts with no STOP; bus idle levels appear on the same edge as reset.
- Internal quarter counter counts 0..QDIV-1. Phase counter q counts 0..3 within a bit. Bit counter counts 7..0 (MSB first).
- IDLE:
  - scl=1, SDA released.
  - start=1 captures addr, clears nack, and enters START. start in any other state is ignored.
- START: scl=1, SDA driven low for 2*QDIV clocks, then ADDR.
- ADDR: shifts out {addr,1'b0} (8 bits). Each bit is 4 quarters:
  - q0: scl=0, SDA updated at the first clock of q0 (sda_oe=~bit).
  - q1: scl=0.
  - q2, q3: scl=1.
  - Then ACK_A.
- ACK_A / ACK_D:
  - One bit period with sda_oe=0.
  - sda_i is sampled on the last clock of q2.
  - sda_i=0: ACK. ACK_A goes to LOAD; ACK_D goes to LOAD, or to STOP if the captured data_last=1.
  - sda_i=1: NACK. Set nack=1 and go to STOP.
- LOAD:
  - scl=0, SDA released, data_ready=1.
  - On data_valid&&data_ready, capture data_in and data_last, drop data_ready the next cycle, and go to DATA.
  - LOAD lasts exactly 1 clock if data_valid is already high. Otherwise SCL is held low indefinitely (master-side stretch).
- DATA: 8 bits, same timing as ADDR, then ACK_D.
- STOP:
  - q0: scl=0, SDA driven low.
  - q1: scl=1, SDA low.
  - q2: scl=1, SDA released.
  - Each quarter lasts QDIV clocks.
  - At the end, pulse done for 1 clock and return to IDLE. busy falls in the same cycle done is asserted.
- SDA changes only while scl=0, except the START and STOP edges.
- No glitches: scl, sda_o and sda_oe are registered outputs.
- Latency: from the start-accept edge to the done pulse is 2Q + 36Q + L + 36Q*N + 3Q clocks.
  - Q=QDIV, N=bytes.
  - L = total LOAD cycles (N when data is always valid).
  - With QDIV=4, N=1, L=1, this is 309 clocks.
- start and data_valid arriving in the same cycle: data is not consumed until LOAD.
- data_valid in non-LOAD states is ignored.

Test Plan:
- QDIV=4, addr=0x50, one byte 0xA5 with data_last=1, data_valid held high, bench ACKs both -> SDA bits 1010000,0 then 10100101, each stable while scl=1. done pulses 309 clocks after start. nack=0.
- addr=0x3C, bench drives sda_i=1 during ACK_A -> STOP follows immediately, nack=1, data_ready never asserts, done pulses once. nack stays 1 until next start accepted.
- 3 bytes 0x11,0x22,0x33, data_valid for byte 2 delayed 20 clocks -> scl held 0 and data_ready=1 for 20 extra clocks. Bytes appear in order. STOP after byte 3 ACK.
- NACK on byte 2 of 3 -> STOP after byte 2 ACK slot, nack=1, byte 3 never requested.
- reset asserted mid-DATA bit 4 -> scl=1, sda_oe=0, busy=0 immediately. No done pulse. New start after release gives a full correct transaction.
- start pulsed repeatedly while busy -> ignored, exactly one transaction and one done pulse.

Source files
------------

// File: rtl/i2c_raw_tx.sv
// I2C master write transmitter: START, address+W, handshaked data bytes, ACK sampling, STOP.
// SCL is push-pull; SDA is open-drain (sda_oe=1 pulls low). All bus outputs are registered.
module i2c_raw_tx #(
   parameter int QDIV = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [6:0] addr,
   input  logic [7:0] data_in,
   input  logic       data_last,
   input  logic       data_valid,
   output logic       data_ready,
   output logic       busy,
   output logic       done,
   output logic       nack,
   output logic       scl,
   output logic       sda_o,
   output logic       sda_oe,
   input  logic       sda_i
);

   localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
   localparam logic [QW-1:0] QMAX = QW'(QDIV - 1);

   typedef enum logic [2:0] {IDLE, START, ADDR, ACK_A, LOAD, DATA, ACK_D, STOP} state_t;

   state_t        state_reg, state_next;
   logic [QW-1:0] quarter_reg, quarter_next;
   logic [1:0]    phase_reg, phase_next;
   logic [2:0]    bit_reg, bit_next;
   logic [7:0]    shift_reg, shift_next;
   logic          last_reg, last_next;
   logic          ack_reg, ack_next;
   logic          nack_reg, nack_next;
   logic          scl_reg, scl_next;
   logic          oe_reg, oe_next;
   logic          ready_reg, ready_next;
   logic          busy_reg, busy_next;
   logic          done_reg, done_next;
   logic          tick;

   assign tick = (quarter_reg == QMAX);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= IDLE;
         quarter_reg <= '0;
         phase_reg   <= 2'd0;
         bit_reg     <= 3'd0;
         shift_reg   <= 8'd0;
         last_reg    <= 1'b0;
         ack_reg     <= 1'b0;
         nack_reg    <= 1'b0;
         scl_reg     <= 1'b1;
         oe_reg      <= 1'b0;
         ready_reg   <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         quarter_reg <= quarter_next;
         phase_reg   <= phase_next;
         bit_reg     <= bit_next;
         shift_reg   <= shift_next;
         last_reg    <= last_next;
         ack_reg     <= ack_next;
         nack_reg    <= nack_next;
         scl_reg     <= scl_next;
         oe_reg      <= oe_next;
         ready_reg   <= ready_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      quarter_next = quarter_reg;
      phase_next   = phase_reg;
      bit_next     = bit_reg;
      shift_next   = shift_reg;
      last_next    = last_reg;
      ack_next     = ack_reg;
      nack_next    = nack_reg;
      done_next    = 1'b0;

      // Quarter/phase timing runs in every timed state; LOAD freezes it so SCL stays low.
      if (state_reg != IDLE && state_reg != LOAD) begin
         quarter_next = tick ? '0 : quarter_reg + 1'b1;
         if (tick) phase_next = phase_reg + 2'd1;
      end

      case (state_reg)
         IDLE: begin
            if (start) begin
               state_next   = START;
               shift_next   = {addr, 1'b0};
               nack_next    = 1'b0;
               quarter_next = '0;
               phase_next   = 2'd0;
            end
         end
         START: begin
            if (tick && phase_reg == 2'd1) begin
               state_next = ADDR;
               phase_next = 2'd0;
               bit_next   = 3'd7;
            end
         end
         ADDR, DATA: begin
            if (tick && phase_reg == 2'd3) begin
               if (bit_reg == 3'd0) begin
                  state_next = (state_reg == ADDR) ? ACK_A : ACK_D;
               end else begin
                  bit_next   = bit_reg - 3'd1;
                  shift_next = {shift_reg[6:0], 1'b0};
               end
            end
         end
         ACK_A, ACK_D: begin
            if (tick && phase_reg == 2'd2) ack_next = sda_i;
            if (tick && phase_reg == 2'd3) begin
               if (ack_reg) begin
                  nack_next  = 1'b1;
                  state_next = STOP;
               end else if (state_reg == ACK_D && last_reg) begin
                  state_next = STOP;
               end else begin
                  state_next = LOAD;
               end
            end
         end
         LOAD: begin
            if (data_valid && ready_reg) begin
               shift_next = data_in;
               last_next  = data_last;
               state_next = DATA;
               bit_next   = 3'd7;
            end
         end
         STOP: begin
            if (tick && phase_reg == 2'd2) begin
               state_next = IDLE;
               done_next  = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      // Bus levels are derived from the upcoming state so they land in registers.
      scl_next   = 1'b1;
      oe_next    = 1'b0;
      ready_next = 1'b0;
      busy_next  = 1'b1;
      case (state_next)
         IDLE:         busy_next = 1'b0;
         START:        oe_next = 1'b1;
         ADDR, DATA: begin
            scl_next = phase_next[1];
            oe_next  = ~shift_next[7];
         end
         ACK_A, ACK_D: scl_next = phase_next[1];
         LOAD: begin
            scl_next   = 1'b0;
            ready_next = 1'b1;
         end
         STOP: begin
            scl_next = (phase_next != 2'd0);
            oe_next  = (phase_next != 2'd2);
         end
         default: busy_next = 1'b1;
      endcase
   end

   assign scl        = scl_reg;
   assign sda_o      = 1'b0;
   assign sda_oe     = oe_reg;
   assign data_ready = ready_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign nack       = nack_reg;

endmodule
